// File: rtl/ifu.sv
// ifu: instruction fetch unit, one fetch in flight, four-state request/response/output/wait loop.
// Optional misaligned-PC detection is compiled in with YSYX_23060251_IFU_MISALIGN_EN.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] npc_i,
    input  logic        npc_valid_i,
    output logic        npc_ready_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        fetch_err_o
);
    typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_err;
    logic        w_mis_en;
    logic        w_mis;
    logic        w_npc_fire;
    logic        w_r_fire;

`ifdef YSYX_23060251_IFU_MISALIGN_EN
    assign w_mis_en = 1'b1;
`else
    assign w_mis_en = 1'b0;
`endif

    assign w_mis      = w_mis_en & (|npc_i[1:0]);
    assign w_npc_fire = npc_ready_o & npc_valid_i;
    assign w_r_fire   = rready_o & rvalid_i;
    assign araddr_o   = r_pc;
    assign pc_o       = r_pc;
    assign inst_o     = r_inst;
    assign fetch_err_o = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_r_fire) begin
                r_inst <= rdata_i;
                r_err  <= rresp_i != 2'b00;
            end
            // A misaligned target is reported straight to decode without touching the bus.
            if (w_npc_fire) begin
                r_pc <= w_mis ? npc_i : {npc_i[31:2], 2'b00};
                if (w_mis) begin
                    r_inst <= '0;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    // Handshake outputs are forced low during reset so nothing escapes the reset cycle.
    always_comb begin
        w_next       = r_state;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        inst_valid_o = 1'b0;
        npc_ready_o  = 1'b0;
        case (r_state)
            S_REQ: begin
                arvalid_o = !reset;
                w_next    = arready_i ? S_RESP : S_REQ;
            end
            S_RESP: begin
                rready_o = !reset;
                w_next   = rvalid_i ? S_OUT : S_RESP;
            end
            S_OUT: begin
                inst_valid_o = !reset;
                w_next       = inst_ready_i ? S_WAIT : S_OUT;
            end
            default: begin
                npc_ready_o = !reset;
                w_next      = npc_valid_i ? (w_mis ? S_OUT : S_REQ) : S_WAIT;
            end
        endcase
    end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, address of the first fetch after reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 npc_i  input  32  next PC from the branch/jump next-PC unit.
REQ-005 npc_valid_i  input  1  npc_i valid; instruction retired.
REQ-006 npc_ready_o  output  1  IFU accepts npc_i.
REQ-007 araddr_o  output  32  fetch address to instruction memory.
REQ-008 arvalid_o  output  1  fetch request valid.
REQ-009 arready_i  input  1  memory accepts request.
REQ-010 rdata_i  input  32  fetched instruction word.
REQ-011 rresp_i  input  2  response code; 2'b00 is OKAY.
REQ-012 rvalid_i  input  1  response valid.
REQ-013 rready_o  output  1  IFU accepts response.
REQ-014 pc_o  output  32  PC of the held instruction.
REQ-015 inst_o  output  32  held instruction word.
REQ-016 inst_valid_o  output  1  pc_o/inst_o valid to decode.
REQ-017 inst_ready_i  input  1  decode accepts instruction.
REQ-018 fetch_err_o  output  1  qualifies inst_valid_o; bus error or misaligned PC.

Function
REQ-019 Every handshake SHALL transfer only in a cycle where valid and ready are both high.
REQ-020 The FSM SHALL have four states: S_REQ, S_RESP, S_OUT, S_WAIT.
REQ-021 In S_REQ: arvalid_o=1 and araddr_o=pc register; arready_i=1 -> S_RESP.
REQ-022 In S_RESP: rready_o=1; rvalid_i=1 -> capture rdata_i into inst_o, set fetch_err_o=(rresp_i!=0), go to S_OUT.
REQ-023 In S_OUT: inst_valid_o=1; inst_o, pc_o and fetch_err_o SHALL remain stable until inst_ready_i=1, then -> S_WAIT.
REQ-024 In S_WAIT: npc_ready_o=1; npc_valid_i=1 -> pc register loads npc_i, -> S_REQ.
REQ-025 araddr_o SHALL show the new PC on the cycle after npc acceptance; npc-to-arvalid latency is 1 cycle.
REQ-026 arvalid_o, rready_o, inst_valid_o and npc_ready_o SHALL each be high only in their own state, and are mutually exclusive.
REQ-027 arvalid_o SHALL NOT drop and araddr_o SHALL NOT change while in S_REQ without arready_i.
REQ-028 rvalid_i outside S_RESP and npc_valid_i outside S_WAIT SHALL be ignored without state change.
REQ-029 Best-case loop: 1 cycle S_REQ, 1 cycle S_RESP, 1 cycle S_OUT, 1 cycle S_WAIT.
REQ-030 A bus error SHALL NOT stall the FSM; the word is delivered with fetch_err_o=1.

Reset
REQ-031 While reset=1: state=S_REQ, pc register=RESET_PC, inst_o=0, fetch_err_o=0.
REQ-032 While reset=1: arvalid_o, rready_o, inst_valid_o and npc_ready_o SHALL all be 0.
REQ-033 In the first cycle after reset deasserts: arvalid_o=1 and araddr_o=RESET_PC.
REQ-034 Reset in any state SHALL abandon the outstanding transaction, with the state, outputs and pc register as in REQ-031/032.

Configuration
REQ-035 Macro YSYX_23060251_IFU_MISALIGN_EN SHALL compile in misaligned-PC detection.
REQ-036 With the macro, an accepted npc_i with bits [1:0]!=0 SHALL skip S_REQ/S_RESP.
REQ-037 With the macro, such a PC goes directly to S_OUT with pc_o=npc_i, inst_o=0, fetch_err_o=1, and no bus request is issued.
REQ-038 Without the macro, the pc register SHALL load {npc_i[31:2],2'b00} and the fetch proceeds normally.

Verification
REQ-039 Release reset, arready_i=1 same cycle, rvalid_i=1 one cycle later with rdata_i=32'h0000_0013 -> inst_valid_o=1 with pc_o=32'h8000_0000, inst_o=32'h0000_0013, fetch_err_o=0.
REQ-040 Hold arready_i=0 for 5 cycles -> arvalid_o=1 and araddr_o unchanged all 5 cycles; single S_RESP entry after arready_i.
REQ-041 inst_ready_i=0 for 3 cycles in S_OUT, with rvalid_i pulsed -> outputs stable; the extra rvalid_i is ignored.
REQ-042 In S_WAIT drive npc_i=32'h8000_0100, npc_valid_i=1 -> next cycle arvalid_o=1, araddr_o=32'h8000_0100.
REQ-043 rresp_i=2'b10 on response -> inst_valid_o=1, fetch_err_o=1, then the normal S_WAIT handshake.
REQ-044 npc_i=32'h8000_0102 -> with macro: no arvalid_o, fetch_err_o=1, pc_o=32'h8000_0102; without macro: araddr_o=32'h8000_0100.
